// File: rtl/mfcc_frame_buf_if.sv
// Bus bundle for the MFCC ping-pong frame buffer: writer stream, reader port and status.
interface mfcc_frame_buf_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
);
  logic              clear;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic              rd_avail;
  logic [ADDR_W:0]   rd_len;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic              rd_release;
  logic [7:0]        drop_cnt;

  modport master (
    output clear, wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
    input  wr_ready, rd_avail, rd_len, rd_data, rd_valid, rd_err, drop_cnt
  );

  modport slave (
    input  clear, wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
    output wr_ready, rd_avail, rd_len, rd_data, rd_valid, rd_err, drop_cnt
  );
endinterface

// File: rtl/mfcc_frame_buf.sv
// Two-bank ping-pong frame buffer: the writer fills one bank while the reader
// randomly accesses the other; both banks are zero-swept after reset or clear.
module mfcc_frame_buf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  mfcc_frame_buf_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLR, FILL} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       clrPtr_q, clrPtr_d;
  logic [ADDR_W-1:0]       wrPtr_q, wrPtr_d;
  logic                    wb_q, wb_d;
  logic                    rb_q, rb_d;
  logic [1:0]              full_q, full_d;
  logic [1:0][ADDR_W:0]    len_q, len_d;
  logic [7:0]              dropCnt_q, dropCnt_d;
  logic [DATA_W-1:0]       rdData_q, rdData_d;
  logic                    rdValid_q, rdValid_d;
  logic                    rdErr_q, rdErr_d;

  logic [DATA_W-1:0]       mem0 [DEPTH];
  logic [DATA_W-1:0]       mem1 [DEPTH];
  logic [1:0]              memWe;
  logic [ADDR_W-1:0]       memAddr;
  logic [DATA_W-1:0]       memWData;
  logic [DATA_W-1:0]       rdWord;

  logic flush, wrReady, accept, closeFrame, releaseBank, rdOk;

  assign flush       = reset | bus.clear;
  assign wrReady     = (state_q == FILL) && !full_q[wb_q];
  assign accept      = bus.wr_valid & wrReady;
  assign closeFrame  = accept & (bus.wr_last | (wrPtr_q == LAST_ADDR));
  assign releaseBank = bus.rd_release & full_q[rb_q];
  assign rdOk        = bus.rd_en & full_q[rb_q] & ({1'b0, bus.rd_addr} < len_q[rb_q]);
  assign rdWord      = rb_q ? mem1[bus.rd_addr] : mem0[bus.rd_addr];

  always_comb begin
    state_d   = state_q;
    clrPtr_d  = clrPtr_q;
    wrPtr_d   = wrPtr_q;
    wb_d      = wb_q;
    rb_d      = rb_q;
    full_d    = full_q;
    len_d     = len_q;
    dropCnt_d = dropCnt_q;
    rdData_d  = rdData_q;
    rdValid_d = 1'b0;
    rdErr_d   = 1'b0;
    memWe     = 2'b00;
    memAddr   = wrPtr_q;
    memWData  = bus.wr_data;

    case (state_q)
      CLR: begin
        memWe    = 2'b11;
        memAddr  = clrPtr_q;
        memWData = '0;
        clrPtr_d = clrPtr_q + 1'b1;
        if (clrPtr_q == LAST_ADDR) state_d = FILL;
      end
      FILL: begin
        if (accept) begin
          memWe   = wb_q ? 2'b10 : 2'b01;
          wrPtr_d = wrPtr_q + 1'b1;
        end
        if (closeFrame) begin
          full_d[wb_q] = 1'b1;
          len_d[wb_q]  = {1'b0, wrPtr_q} + 1'b1;
          wb_d         = ~wb_q;
          wrPtr_d      = '0;
        end
        if (bus.wr_valid && !wrReady && dropCnt_q != 8'hFF) dropCnt_d = dropCnt_q + 8'd1;
      end
      default: state_d = CLR;
    endcase

    // The read samples the current read bank before any release in this cycle moves rb.
    if (bus.rd_en) begin
      rdValid_d = rdOk;
      rdErr_d   = ~rdOk;
      rdData_d  = rdOk ? rdWord : '0;
    end

    if (releaseBank) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end

    if (flush) memWe = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q   <= CLR;
      clrPtr_q  <= '0;
      wrPtr_q   <= '0;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      full_q    <= '0;
      len_q     <= '0;
      dropCnt_q <= '0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
      rdErr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clrPtr_q  <= clrPtr_d;
      wrPtr_q   <= wrPtr_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      full_q    <= full_d;
      len_q     <= len_d;
      dropCnt_q <= dropCnt_d;
      rdData_q  <= rdData_d;
      rdValid_q <= rdValid_d;
      rdErr_q   <= rdErr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe[0]) mem0[memAddr] <= memWData;
    if (memWe[1]) mem1[memAddr] <= memWData;
  end

  assign bus.wr_ready = wrReady;
  assign bus.rd_avail = full_q[rb_q];
  assign bus.rd_len   = len_q[rb_q];
  assign bus.rd_data  = rdData_q;
  assign bus.rd_valid = rdValid_q;
  assign bus.rd_err   = rdErr_q;
  assign bus.drop_cnt = dropCnt_q;
endmodule

// File: tb/tb_mfcc_frame_buf.sv
// Directed-plus-random bench for mfcc_frame_buf, compared every cycle against a
// frame-level reference model.
module tb_mfcc_frame_buf;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mfcc_frame_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mfcc_frame_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: banks as plain arrays, readiness as a countdown of sweep cycles.
  int sweepLeft, wBank, rBank, fillCount, drops;
  int bankData [2][DEPTH];
  bit bankFull [2];
  int bankLen  [2];
  int expData;
  bit expValid, expErr;
  logic [DATA_W-1:0] fiveWords [5];

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    checkValue("wr_ready", 32'(bus.wr_ready), (sweepLeft == 0 && !bankFull[wBank]) ? 1 : 0);
    checkValue("rd_avail", 32'(bus.rd_avail), 32'(bankFull[rBank]));
    checkValue("rd_len",   32'(bus.rd_len),   bankLen[rBank]);
    checkValue("rd_data",  32'(bus.rd_data),  expData);
    checkValue("rd_valid", 32'(bus.rd_valid), 32'(expValid));
    checkValue("rd_err",   32'(bus.rd_err),   32'(expErr));
    checkValue("drop_cnt", 32'(bus.drop_cnt), drops);
  endtask

  task automatic modelStep();
    bit relNow;
    if (reset || bus.clear) begin
      sweepLeft = DEPTH;
      wBank = 0; rBank = 0; fillCount = 0; drops = 0;
      expData = 0; expValid = 1'b0; expErr = 1'b0;
      for (int b = 0; b < 2; b++) begin
        bankFull[b] = 1'b0;
        bankLen[b]  = 0;
        for (int i = 0; i < DEPTH; i++) bankData[b][i] = 0;
      end
      return;
    end
    relNow = bus.rd_release && bankFull[rBank];
    if (bus.rd_en) begin
      if (bankFull[rBank] && int'(bus.rd_addr) < bankLen[rBank]) begin
        expData = bankData[rBank][bus.rd_addr]; expValid = 1'b1; expErr = 1'b0;
      end else begin
        expData = 0; expValid = 1'b0; expErr = 1'b1;
      end
    end else begin
      expValid = 1'b0; expErr = 1'b0;
    end
    if (sweepLeft > 0) begin
      sweepLeft--;
    end else if (bus.wr_valid) begin
      if (!bankFull[wBank]) begin
        bankData[wBank][fillCount] = int'(bus.wr_data);
        fillCount++;
        if (bus.wr_last || fillCount == DEPTH) begin
          bankFull[wBank] = 1'b1;
          bankLen[wBank]  = fillCount;
          wBank ^= 1;
          fillCount = 0;
        end
      end else if (drops < 255) begin
        drops++;
      end
    end
    if (relNow) begin
      bankFull[rBank] = 1'b0;
      rBank ^= 1;
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input bit last,
                               input bit rden, input logic [ADDR_W-1:0] addr,
                               input bit rel, input bit clr);
    bus.wr_valid   = v;
    bus.wr_data    = d;
    bus.wr_last    = last;
    bus.rd_en      = rden;
    bus.rd_addr    = addr;
    bus.rd_release = rel;
    bus.clear      = clr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic tick(input bit doCheck = 1'b1);
    if (doCheck) checkOutput();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(1'b0);
    tick();
    checkValue("rst_rd_avail", 32'(bus.rd_avail), 0);
    checkValue("rst_rd_valid", 32'(bus.rd_valid), 0);
    checkValue("rst_drop_cnt", 32'(bus.drop_cnt), 0);
    checkValue("rst_wr_ready", 32'(bus.wr_ready), 0);
    reset = 1'b0;

    // Sweep: ready only after DEPTH idle cycles.
    for (int i = 0; i < DEPTH - 1; i++) tick();
    checkValue("ready_before_sweep_end", 32'(bus.wr_ready), 0);
    tick();
    checkValue("ready_after_sweep", 32'(bus.wr_ready), 1);

    // 13-word frame with explicit last.
    for (int i = 1; i <= 13; i++) begin
      applyStimulus(1'b1, 16'(i), i == 13, 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    idle();
    checkValue("f13_avail", 32'(bus.rd_avail), 1);
    checkValue("f13_len", 32'(bus.rd_len), 13);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 7'd12, 1'b0, 1'b0);
    tick();
    idle();
    checkValue("f13_rd12_data", 32'(bus.rd_data), 32'h000D);
    checkValue("f13_rd12_valid", 32'(bus.rd_valid), 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 7'd13, 1'b0, 1'b0);
    tick();
    idle();
    checkValue("f13_rd13_err", 32'(bus.rd_err), 1);
    checkValue("f13_rd13_data", 32'(bus.rd_data), 0);
    tick();
    checkValue("err_is_pulse", 32'(bus.rd_err), 0);

    // Release bank 0, then a read with nothing available.
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0);
    tick();
    idle();
    checkValue("noavail_err", 32'(bus.rd_err), 1);

    // Full-depth frame auto-closes, then a 5-word frame fills the other bank.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    idle();
    checkValue("auto_avail", 32'(bus.rd_avail), 1);
    checkValue("auto_len", 32'(bus.rd_len), 128);
    checkValue("auto_ready", 32'(bus.wr_ready), 1);
    for (int i = 0; i < 5; i++) begin
      fiveWords[i] = 16'($urandom);
      applyStimulus(1'b1, fiveWords[i], i == 4, 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkValue("both_full_ready", 32'(bus.wr_ready), 0);
    tick();
    idle();
    checkValue("first_drop", 32'(bus.drop_cnt), 1);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 7'($urandom_range(0, DEPTH - 1)), 1'b0, 1'b0);
      tick();
    end

    // Read+release together, then read+release on bank 0 while bank 1 completes.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0);
    tick();
    idle();
    checkValue("relread_valid", 32'(bus.rd_valid), 1);
    checkValue("relread_len", 32'(bus.rd_len), 5);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 16'($urandom), 1'b1, 1'b1, 7'd4, 1'b1, 1'b0);
    tick();
    idle();
    checkValue("swap_rd_data", 32'(bus.rd_data), 32'(fiveWords[4]));
    checkValue("swap_avail", 32'(bus.rd_avail), 1);
    checkValue("swap_len", 32'(bus.rd_len), 7);

    // Fill the free bank, then saturate the drop counter.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'($urandom), i == 2, 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    idle();
    checkValue("drop_saturated", 32'(bus.drop_cnt), 255);

    // Partial frame stays invisible; clear overrides all concurrent activity.
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    idle();
    checkValue("partial_len", 32'(bus.rd_len), 3);
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1, 7'd0, 1'b1, 1'b1);
    tick();
    idle();
    checkValue("clr_avail", 32'(bus.rd_avail), 0);
    checkValue("clr_drop", 32'(bus.drop_cnt), 0);
    checkValue("clr_ready", 32'(bus.wr_ready), 0);
    checkValue("clr_valid", 32'(bus.rd_valid), 0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    idle();
    checkValue("clr_sweep_drop", 32'(bus.drop_cnt), 0);
    checkValue("clr_sweep_ready", 32'(bus.wr_ready), 1);

    // Clear in the middle of a sweep restarts the full sweep.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    idle();
    for (int i = 0; i < DEPTH - 1; i++) tick();
    checkValue("midsweep_not_ready", 32'(bus.wr_ready), 0);
    tick();
    checkValue("midsweep_ready", 32'(bus.wr_ready), 1);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 9) == 0,
                    1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
                    $urandom_range(0, 7) == 0, 1'b0);
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
